// File: rtl/frame_streamer.sv
// frame_streamer
//   Buffers a push-only column stream into two FRAME_LEN-deep banks (ping-pong)
//   and replays each completed bank as one frame on a valid/last/ready stream.
//   A completed bank is presented on the cycle after its final write when the
//   reader is idle. Back-to-back frames stream without a bubble.
//
// Ports
//   clk_i       clock
//   rst_n_i     synchronous active-low reset
//   data_i      input column (COLUMN_LEN*BW bits)
//   valid_i     input column present; never stalled, dropped if no bank is free
//   data_o      output column (registered)
//   valid_o     output column valid (registered)
//   last_o      high with column FRAME_LEN-1 of each frame (registered)
//   ready_i     downstream ready
//   overflow_o  sticky, set when any input column is dropped
//   drop_cnt_o  (only with FRAME_STREAMER_DROP_CNT_EN) saturating drop count
//
// Optional feature macro: FRAME_STREAMER_DROP_CNT_EN
module frame_streamer #(
    parameter int FRAME_LEN  = 50,
    parameter int COLUMN_LEN = 1,
    parameter int BW         = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [COLUMN_LEN*BW-1:0] data_i,
    input  logic                     valid_i,
    output logic [COLUMN_LEN*BW-1:0] data_o,
    output logic                     valid_o,
    output logic                     last_o,
    input  logic                     ready_i,
    output logic                     overflow_o
`ifdef FRAME_STREAMER_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt_o
`endif
);
    localparam int            DW       = COLUMN_LEN * BW;
    localparam int            IW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e        state_q;
    logic [DW-1:0] mem_q [2][FRAME_LEN];
    logic [1:0]    full_q, full_d, full_eff;
    logic          wr_bank_q, rd_bank_q;
    logic [IW-1:0] wr_idx_q, rd_idx_q, rd_idx_nxt;
    logic [DW-1:0] data_q;
    logic          valid_q, last_q, overflow_q;
    logic          wr_ok, wr_done, drop, hs, release_bank;

    always_comb begin
        wr_ok        = valid_i & ~full_q[wr_bank_q];
        wr_done      = wr_ok & (wr_idx_q == LAST_IDX);
        drop         = valid_i & full_q[wr_bank_q];
        hs           = valid_q & ready_i;
        release_bank = (state_q == SEND) & hs & last_q;
        rd_idx_nxt   = rd_idx_q + 1'b1;
        // Reader sees a bank completing this cycle as already full; this is
        // what gives the one-cycle completion-to-valid latency. Column 0 is
        // always in memory by then since FRAME_LEN >= 2.
        full_eff = full_q;
        if (wr_done) full_eff[wr_bank_q] = 1'b1;
        // Writer and reader never own the same bank, so set/clear cannot collide.
        full_d = full_eff;
        if (release_bank) full_d[rd_bank_q] = 1'b0;
    end

    // Bank storage carries no reset: full flags gate every read.
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_bank_q][wr_idx_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_idx_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            overflow_q <= overflow_q | drop;

            // Writer: a dropped column leaves the index untouched, so writing
            // resumes at index 0 once the bank is released.
            if (wr_ok) begin
                if (wr_done) begin
                    wr_idx_q  <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_idx_q  <= wr_idx_q + 1'b1;
                end
            end

            // Reader
            case (state_q)
                IDLE: begin
                    if (full_eff[rd_bank_q]) begin
                        data_q   <= mem_q[rd_bank_q][0];
                        valid_q  <= 1'b1;
                        last_q   <= 1'b0;
                        rd_idx_q <= '0;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    // Without a handshake everything holds.
                    if (hs) begin
                        if (last_q) begin
                            rd_bank_q <= ~rd_bank_q;
                            rd_idx_q  <= '0;
                            last_q    <= 1'b0;
                            if (full_eff[~rd_bank_q]) begin
                                data_q  <= mem_q[~rd_bank_q][0];
                            end else begin
                                valid_q <= 1'b0;
                                state_q <= IDLE;
                            end
                        end else begin
                            rd_idx_q <= rd_idx_nxt;
                            data_q   <= mem_q[rd_bank_q][rd_idx_nxt];
                            last_q   <= (rd_idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign last_o     = last_q;
    assign overflow_o = overflow_q;

`ifdef FRAME_STREAMER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer with FRAME_LEN=4, one 8-bit element per column.
// Reference model: accepted columns gather into a partial frame; a finished
// frame joins a queue of pending frames (at most two, one per bank). A column
// is dropped when two frames are pending. The output shows the head pending
// frame at a read position; valid_o is high whenever a frame is pending.
module tb_frame_streamer;
    localparam int FL = 4;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       last_o;
    logic       ready_i;
    logic       overflow_o;
`ifdef FRAME_STREAMER_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    frame_streamer #(.FRAME_LEN(FL), .COLUMN_LEN(1), .BW(8)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .last_o     (last_o),
        .ready_i    (ready_i),
        .overflow_o (overflow_o)
`ifdef FRAME_STREAMER_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [7:0] part[$];
    logic [7:0] pend[$];
    int         pos  = 0;
    logic       ovf  = 1'b0;
    int         dcnt = 0;

    task automatic check_outputs(input string tag);
        logic exp_v;
        exp_v = (pend.size() >= FL);
        checks++;
        assert (valid_o === exp_v) else begin
            errors++;
            $error("FAIL %s valid_o got %b expected %b", tag, valid_o, exp_v);
        end
        if (exp_v) begin
            checks++;
            assert (data_o === pend[pos]) else begin
                errors++;
                $error("FAIL %s data_o got %h expected %h", tag, data_o, pend[pos]);
            end
            checks++;
            assert (last_o === (pos == FL-1)) else begin
                errors++;
                $error("FAIL %s last_o got %b expected %b", tag, last_o, (pos == FL-1));
            end
        end
        checks++;
        assert (overflow_o === ovf) else begin
            errors++;
            $error("FAIL %s overflow_o got %b expected %b", tag, overflow_o, ovf);
        end
`ifdef FRAME_STREAMER_DROP_CNT_EN
        checks++;
        assert (drop_cnt_o === 16'(dcnt)) else begin
            errors++;
            $error("FAIL %s drop_cnt_o got %0d expected %0d", tag, drop_cnt_o, dcnt);
        end
`endif
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input string tag);
        logic hs_m;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        hs_m = (pend.size() >= FL) && r;
        if (v) begin
            if (pend.size() == 2*FL) begin
                ovf = 1'b1;
                if (dcnt < 65535) dcnt++;
            end else begin
                part.push_back(d);
            end
        end
        if (hs_m) begin
            if (pos == FL-1) begin
                repeat (FL) void'(pend.pop_front());
                pos = 0;
            end else begin
                pos++;
            end
        end
        if (part.size() == FL) begin
            foreach (part[i]) pend.push_back(part[i]);
            part.delete();
        end
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        part.delete();
        pend.delete();
        pos  = 0;
        ovf  = 1'b0;
        dcnt = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        check_outputs(tag);
        checks++;
        assert (data_o === 8'h00) else begin
            errors++;
            $error("FAIL %s data_o got %h expected 00", tag, data_o);
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        ready_i = 1'b0;
        @(negedge clk_i);
        do_reset("reset");

        // Single frame at full throughput
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b1, "single");
        repeat (6) cyc(1'b0, 8'h00, 1'b1, "single_drain");

        // Backpressure with ready pattern 1,0,0,1,0,0,...
        for (int k = 0; k < 18; k++)
            cyc(k < 4, 8'(k + 1), (k % 3) == 0, "bp");

        // Ping-pong, back-to-back frames; B's last write meets A's last handshake
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b1, "pingpong");
        repeat (6) cyc(1'b0, 8'h00, 1'b1, "pingpong_drain");

        // Overflow with downstream stalled
        for (int i = 0; i < 12; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0, "ovf_fill");
        repeat (12) cyc(1'b0, 8'h00, 1'b1, "ovf_drain");

        // Reset after two columns of a frame have been taken
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b1, "rst_fill");
        repeat (2) cyc(1'b0, 8'h00, 1'b1, "rst_partial");
        do_reset("rst_mid");
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b1, "after_rst");
        repeat (6) cyc(1'b0, 8'h00, 1'b1, "after_rst_drain");

        // Release/complete coincidence after a stalled start
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0, "simul_a");
        repeat (2) cyc(1'b0, 8'h00, 1'b0, "simul_stall");
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b1, "simul_b");
        repeat (6) cyc(1'b0, 8'h00, 1'b1, "simul_drain");

        // Random traffic with varying backpressure
        for (int k = 0; k < 600; k++) begin
            logic       v, r;
            logic [7:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            r = (k < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) != 0);
            cyc(v, d, r, "random");
        end
        repeat (12) cyc(1'b0, 8'h00, 1'b1, "final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
